// File: rtl/uart_pkg.sv
// Shared types and framing constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Power-of-two synchronous FIFO with occupancy count; head word is visible on rdata_o.
module uart_tx_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned LvlW  = PtrW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [LvlW-1:0]  level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      level_d = level_q + LvlW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered 8N1 UART transmitter; back-to-back frames leave no idle gap on the line.
module uart_tx
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned DIV_W = 32,
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [DIV_W-1:0] cfg_divider,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             ser_tx,
  output logic             busy,
  output logic [LvlW-1:0]  fifo_level
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             ser_q, ser_d;

  logic             pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [DIV_W-1:0] div_eff;
  logic             bit_end;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Dividers below 1 would give a one-cycle bit; clamp to a two-cycle minimum.
  assign div_eff = (cfg_divider < DIV_W'(2)) ? DIV_W'(1) : cfg_divider;
  assign bit_end = (cnt_q == div_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ser_q   <= STOP_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          div_d   = div_eff;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            div_d   = div_eff;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the output flop changes with the state.
  always_comb begin
    ser_d = STOP_BIT;
    unique case (state_d)
      IDLE:    ser_d = STOP_BIT;
      START:   ser_d = START_BIT;
      DATA:    ser_d = shift_d[0];
      STOP:    ser_d = STOP_BIT;
      default: ser_d = STOP_BIT;
    endcase
  end

  assign ser_tx   = ser_q;
  assign tx_ready = !fifo_full;
  assign busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed and randomized frames against a bit-sequence model.
module tb_uart_tx;

  localparam int DEPTH = 8;
  localparam int DIV_W = 32;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic [DIV_W-1:0] cfg_divider = 32'd4;
  logic             tx_valid = 1'b0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_ready;
  logic             ser_tx;
  logic             busy;
  logic [LVL_W-1:0] fifo_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] q [16];
  logic [7:0] dec;
  string      line;
  logic       done;
  int         max_lvl;
  logic       ready_full_obs;
  logic       ready_low_bad;
  int         nb;
  int         per;
  logic       line_dev;
  logic       busy_dev;

  uart_tx #(
    .DEPTH (DEPTH),
    .DIV_W (DIV_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_divider (cfg_divider),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ser_tx      (ser_tx),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit period in clock cycles for a given divider setting.
  function automatic int period(input logic [31:0] d);
    return ((d < 2) ? 1 : int'(d)) + 1;
  endfunction

  // Expected line level for frame bit i: start, eight data bits LSB first, stop.
  function automatic logic exp_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("push_timeout", 32'(tx_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic end_push();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Waits up to max_wait extra cycles for a start bit, then checks every cycle of the frame.
  task automatic check_frame(input logic [7:0] b, input int p, input int max_wait,
                             output logic [7:0] d8);
    int   n = 0;
    logic e;
    logic obs;
    d8 = 8'h00;
    @(negedge clk);
    while (ser_tx !== 1'b0 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("start_%02h", b), 32'(ser_tx), 32'd0);
    if (ser_tx !== 1'b0) return;
    for (int i = 0; i < 10; i++) begin
      e   = exp_bit(b, i);
      obs = e;
      for (int k = 0; k < p; k++) begin
        if (i != 0 || k != 0) @(negedge clk);
        if (ser_tx !== e) obs = ser_tx;
        if (k == p / 2 && i >= 1 && i <= 8) d8[i-1] = ser_tx;
      end
      chk($sformatf("bit%0d_%02h", i, b), 32'(obs), 32'(e));
    end
  endtask

  initial begin
    // Reset values
    #1 resetn = 1'b0;
    #1;
    chk("rst_ser", 32'(ser_tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    repeat (3) @(negedge clk);

    // First push right after release, single 0x41 frame at divider 4
    resetn      = 1'b1;
    cfg_divider = 32'd4;
    tx_valid    = 1'b1;
    tx_data     = 8'h41;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("first_push_level", 32'(fifo_level), 32'd1);
    chk("first_push_busy", 32'(busy), 32'd1);
    chk("first_push_ser", 32'(ser_tx), 32'd1);
    check_frame(8'h41, 5, 0, dec);
    chk("dec_41", 32'(dec), 32'h41);
    chk("busy_last_cycle", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("idle_ser", 32'(ser_tx), 32'd1);

    // Ten back-to-back bytes: FIFO fills, frames contiguous, order preserved
    for (int i = 0; i < 10; i++) q[i] = 8'($urandom);
    done           = 1'b0;
    max_lvl        = 0;
    ready_full_obs = 1'b1;
    ready_low_bad  = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) push_byte(q[i]);
        end_push();
      end
      begin
        check_frame(q[0], 5, 2, dec);
        chk("dec_b2b_0", 32'(dec), 32'(q[0]));
        for (int i = 1; i < 10; i++) begin
          check_frame(q[i], 5, 0, dec);
          chk($sformatf("dec_b2b_%0d", i), 32'(dec), 32'(q[i]));
        end
        done = 1'b1;
      end
      begin
        for (int n = 0; n < 2000 && !done; n++) begin
          @(negedge clk);
          if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
          if (int'(fifo_level) == DEPTH) ready_full_obs = tx_ready;
          if (int'(fifo_level) < DEPTH && tx_ready !== 1'b1) ready_low_bad = 1'b1;
        end
      end
    join
    chk("max_level", 32'(max_lvl), 32'(DEPTH));
    chk("ready_at_full", 32'(ready_full_obs), 32'd0);
    chk("ready_below_full", 32'(ready_low_bad), 32'd0);
    @(negedge clk);
    chk("b2b_busy_end", 32'(busy), 32'd0);
    chk("b2b_level_end", 32'(fifo_level), 32'd0);

    // Divider change mid-frame only affects the next frame
    q[0] = 8'($urandom);
    q[1] = 8'($urandom);
    fork
      begin
        push_byte(q[0]);
        push_byte(q[1]);
        end_push();
        repeat (20) @(negedge clk);
        cfg_divider = 32'd9;
      end
      begin
        check_frame(q[0], 5, 2, dec);
        check_frame(q[1], 10, 0, dec);
        chk("dec_div10", 32'(dec), 32'(q[1]));
      end
    join
    @(negedge clk);
    chk("div_busy_end", 32'(busy), 32'd0);

    // Randomized bursts, including the clamped divider values 0 and 1
    for (int it = 0; it < 4; it++) begin
      cfg_divider = (it < 2) ? 32'(it) : 32'($urandom_range(2, 7));
      per = period(cfg_divider);
      nb  = $urandom_range(1, 12);
      for (int i = 0; i < nb; i++) q[i] = 8'($urandom);
      fork
        begin
          for (int i = 0; i < nb; i++) push_byte(q[i]);
          end_push();
        end
        begin
          for (int i = 0; i < nb; i++) begin
            check_frame(q[i], per, (i == 0) ? 2 : 0, dec);
            chk($sformatf("dec_rnd%0d_%0d", it, i), 32'(dec), 32'(q[i]));
          end
        end
      join
      @(negedge clk);
      chk($sformatf("rnd%0d_busy_end", it), 32'(busy), 32'd0);
    end

    // Serial display model: decode "Hi\n" at the matching bit time
    cfg_divider = 32'd7;
    q[0] = 8'h48;
    q[1] = 8'h69;
    q[2] = 8'h0a;
    line = "";
    fork
      begin
        for (int i = 0; i < 3; i++) push_byte(q[i]);
        end_push();
      end
      begin
        for (int i = 0; i < 3; i++) begin
          check_frame(q[i], 8, (i == 0) ? 2 : 0, dec);
          if (dec == 8'h0a) $display("output: %s", line);
          else line = $sformatf("%s%c", line, dec);
        end
      end
    join
    checks++;
    assert (line == "Hi") else begin
      errors++;
      $error("FAIL display observed=%s expected=Hi", line);
    end

    // Reset during data bit 3 with three bytes still queued
    cfg_divider = 32'd4;
    q[0] = 8'hF7;
    for (int i = 1; i < 4; i++) q[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 4; i++) push_byte(q[i]);
        end_push();
      end
      begin
        int n = 0;
        @(negedge clk);
        while (ser_tx !== 1'b0 && n < 10) begin
          @(negedge clk);
          n++;
        end
        chk("rstmid_start", 32'(ser_tx), 32'd0);
        repeat (4 * 5 + 2) @(negedge clk);
        chk("rstmid_bit3", 32'(ser_tx), 32'd0);
        chk("rstmid_level", 32'(fifo_level), 32'd3);
        #2 resetn = 1'b0;
        #1;
        chk("rstmid_ser", 32'(ser_tx), 32'd1);
        chk("rstmid_level0", 32'(fifo_level), 32'd0);
        chk("rstmid_ready", 32'(tx_ready), 32'd1);
        chk("rstmid_busy", 32'(busy), 32'd0);
      end
    join
    @(negedge clk);
    resetn   = 1'b1;
    line_dev = 1'b0;
    busy_dev = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1) line_dev = 1'b1;
      if (busy !== 1'b0) busy_dev = 1'b1;
    end
    chk("post_rst_line_idle", 32'(line_dev), 32'd0);
    chk("post_rst_no_busy", 32'(busy_dev), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
